// File: rtl/check_sequence.sv
// rtl/check_sequence.sv - replays a stored move sequence against debounced player key presses
//
// Walks moves 0..level of a one-hot move memory. For each move it reads the
// memory, waits for a press, compares it with the stored move and then waits
// for all buttons to be released. It ends with a one-cycle pass or fail pulse.
//
// Optional feature macro: CHECK_TIMEOUT_EN
//   When defined, a move that sees no press for TIMEOUT_CYCLES cycles fails.
//   When undefined, no counter exists and the check waits indefinitely.
//
// Ports
//   clock     in   system clock, rising edge
//   reset     in   synchronous, active-low reset
//   start     in   begin a check; sampled only while idle
//   level     in   [2:0] index of last stored move; latched on accepted start
//   keys      in   [3:0] debounced buttons, active-high
//   addressR  out  [4:0] move-memory read address, always {2'b00, moveNum}
//   qR        in   [3:0] move-memory read data, valid one cycle after addressR
//   moveNum   out  [2:0] index of the move being checked
//   busy      out  high whenever a check is in progress
//   pass      out  one-cycle pulse: every move matched
//   fail      out  one-cycle pulse: wrong press or timeout
module check_sequence #(
  parameter logic [25:0] TIMEOUT_CYCLES = 26'd50_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] level,
  input  logic [3:0] keys,
  output logic [4:0] addressR,
  input  logic [3:0] qR,
  output logic [2:0] moveNum,
  output logic       busy,
  output logic       pass,
  output logic       fail
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_READ,
    S_MEM,
    S_WAIT_PRESS,
    S_WAIT_RELEASE,
    S_PASS,
    S_FAIL
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [2:0] level_q;
  logic [2:0] move_q;
  logic [3:0] expected;
  logic       keys_idle;
  logic       last_move;

  assign keys_idle = (keys == 4'b0000);
  assign last_move = (move_q == level_q);

`ifdef CHECK_TIMEOUT_EN
  logic [25:0] wait_count;
  logic        timed_out;

  // Counter value k is reached in the (k+1)th cycle of waiting, so the
  // last idle cycle is the one where it reads TIMEOUT_CYCLES-1.
  assign timed_out = (wait_count == TIMEOUT_CYCLES - 26'd1);
`endif

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_ARM;
      end
      S_ARM: begin
        // Buttons still held from before the start are never taken as a press.
        if (keys_idle) state_next = S_READ;
      end
      S_READ: begin
        state_next = S_MEM;
      end
      S_MEM: begin
        state_next = S_WAIT_PRESS;
      end
      S_WAIT_PRESS: begin
        // keys==0 is tested first so an empty (all-zero) memory word cannot
        // be matched by simply not pressing anything.
        if (keys_idle) begin
`ifdef CHECK_TIMEOUT_EN
          if (timed_out) state_next = S_FAIL;
`endif
        end else if (keys == expected) begin
          state_next = S_WAIT_RELEASE;
        end else begin
          state_next = S_FAIL;
        end
      end
      S_WAIT_RELEASE: begin
        if (keys_idle) state_next = last_move ? S_PASS : S_READ;
      end
      S_PASS: begin
        state_next = S_IDLE;
      end
      S_FAIL: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= S_IDLE;
      level_q  <= 3'd0;
      move_q   <= 3'd0;
      expected <= 4'b0000;
`ifdef CHECK_TIMEOUT_EN
      wait_count <= 26'd0;
`endif
    end else begin
      state <= state_next;
      if (state == S_IDLE && start) begin
        level_q <= level;
        move_q  <= 3'd0;
      end
      if (state == S_MEM) begin
        expected <= qR;
      end
      // Never increments past the latched level, so level 7 ends at 7.
      if (state == S_WAIT_RELEASE && keys_idle && !last_move) begin
        move_q <= move_q + 3'd1;
      end
`ifdef CHECK_TIMEOUT_EN
      if (state == S_MEM) begin
        wait_count <= 26'd0;
      end else if (state == S_WAIT_PRESS) begin
        wait_count <= wait_count + 26'd1;
      end
`endif
    end
  end

  assign addressR = {2'b00, move_q};
  assign moveNum  = move_q;
  assign busy     = (state != S_IDLE);
  assign pass     = (state == S_PASS);
  assign fail     = (state == S_FAIL);

endmodule

// File: tb/tb_check_sequence.sv
// tb/tb_check_sequence.sv - scoreboard bench for check_sequence
module tb_check_sequence;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [2:0] level = 3'd0;
  logic [3:0] keys  = 4'b0000;
  logic [3:0] qR    = 4'b0000;
  logic [4:0] addressR;
  logic [2:0] moveNum;
  logic       busy;
  logic       pass;
  logic       fail;

  logic [3:0] mem [0:31];
  logic [4:0] exp_q [$];
  logic [4:0] got_q [$];
  logic [4:0] addr_log [$];
  logic [4:0] sb_exp;
  logic [4:0] sb_got;
  int         compared   = 0;
  int         mismatched = 0;

  always #5 clock = ~clock;

  check_sequence #(.TIMEOUT_CYCLES(26'd16)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .level    (level),
    .keys     (keys),
    .addressR (addressR),
    .qR       (qR),
    .moveNum  (moveNum),
    .busy     (busy),
    .pass     (pass),
    .fail     (fail)
  );

  // Synchronous-read move memory: data one cycle after the address.
  always @(posedge clock) qR <= mem[addressR];

  // Result monitor: every pass/fail pulse becomes one scoreboard entry
  // {pass, fail, moveNum}; addresses seen while busy are logged in order.
  always @(negedge clock) begin
    if (pass || fail) begin
      got_q.push_back({pass, fail, moveNum});
      compared++;
      if (pass && fail) begin
        mismatched++;
        $display("FAIL pass_fail_exclusive: pass=%b fail=%b, required not both", pass, fail);
      end
    end
    if (busy && (addr_log.size() == 0 || addr_log[$] != addressR))
      addr_log.push_back(addressR);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic start_check(input logic [2:0] lvl);
    start = 1'b1;
    level = lvl;
    tick(1);
    start = 1'b0;
  endtask

  task automatic press(input logic [3:0] v);
    keys = v;
    tick(2);
    keys = 4'b0000;
    tick(3);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick(2);
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b required 0", busy); end
    compared++; if (pass !== 1'b0) begin mismatched++; $display("FAIL reset_pass: got %b required 0", pass); end
    compared++; if (fail !== 1'b0) begin mismatched++; $display("FAIL reset_fail: got %b required 0", fail); end
    compared++; if (moveNum !== 3'd0) begin mismatched++; $display("FAIL reset_movenum: got %0d required 0", moveNum); end
    compared++; if (addressR !== 5'd0) begin mismatched++; $display("FAIL reset_address: got %0d required 0", addressR); end
    reset = 1'b1;
    tick(1);
    got_q.delete();
    addr_log.delete();
  endtask

  task automatic test_min_latency;
    mem[0] = 4'b0010;
    exp_q.push_back({1'b1, 1'b0, 3'd0});
    start_check(3'd0);
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL latency_arm_busy: got %b required 1", busy); end
    tick(3);
    keys = 4'b0010;
    tick(1);
    keys = 4'b0000;
    tick(1);
    compared++; if (pass !== 1'b1) begin mismatched++; $display("FAIL latency_pass: got %b required 1 five cycles after arm", pass); end
    tick(1);
    compared++; if (pass !== 1'b0 || busy !== 1'b0) begin mismatched++; $display("FAIL latency_after_pass: pass=%b busy=%b required 0 0", pass, busy); end
    for (int w = 0; w < 40 && got_q.size() < exp_q.size(); w++) tick(1);
    while (exp_q.size() != 0) begin
      sb_exp = exp_q.pop_front();
      if (got_q.size() != 0) sb_got = got_q.pop_front(); else sb_got = 5'bxxxxx;
      compared++; if (sb_got !== sb_exp) begin mismatched++; $display("FAIL latency_result: got %b required %b", sb_got, sb_exp); end
    end
    compared++; if (got_q.size() != 0) begin mismatched++; $display("FAIL latency_extra: %0d extra pulses, required 0", got_q.size()); end
    got_q.delete();
  endtask

  task automatic test_basic_pass;
    mem[0] = 4'b0001; mem[1] = 4'b0100; mem[2] = 4'b1000;
    exp_q.push_back({1'b1, 1'b0, 3'd2});
    start_check(3'd2);
    tick(3);
    press(4'b0001);
    press(4'b0100);
    press(4'b1000);
    for (int w = 0; w < 40 && got_q.size() < exp_q.size(); w++) tick(1);
    while (exp_q.size() != 0) begin
      sb_exp = exp_q.pop_front();
      if (got_q.size() != 0) sb_got = got_q.pop_front(); else sb_got = 5'bxxxxx;
      compared++; if (sb_got !== sb_exp) begin mismatched++; $display("FAIL basic_result: got %b required %b", sb_got, sb_exp); end
    end
    tick(3);
    compared++; if (got_q.size() != 0) begin mismatched++; $display("FAIL basic_extra: %0d extra pulses, required 0", got_q.size()); end
    got_q.delete();
  endtask

  task automatic test_mismatch;
    mem[0] = 4'b0001; mem[1] = 4'b0100; mem[2] = 4'b1000;
    exp_q.push_back({1'b0, 1'b1, 3'd1});
    start_check(3'd2);
    tick(3);
    press(4'b0001);
    keys = 4'b0010;
    tick(1);
    compared++; if (fail !== 1'b1) begin mismatched++; $display("FAIL mismatch_fail: got %b required 1", fail); end
    compared++; if (moveNum !== 3'd1) begin mismatched++; $display("FAIL mismatch_movenum: got %0d required 1", moveNum); end
    keys = 4'b0000;
    tick(1);
    compared++; if (busy !== 1'b0 || fail !== 1'b0) begin mismatched++; $display("FAIL mismatch_after: busy=%b fail=%b required 0 0", busy, fail); end
    for (int w = 0; w < 40 && got_q.size() < exp_q.size(); w++) tick(1);
    while (exp_q.size() != 0) begin
      sb_exp = exp_q.pop_front();
      if (got_q.size() != 0) sb_got = got_q.pop_front(); else sb_got = 5'bxxxxx;
      compared++; if (sb_got !== sb_exp) begin mismatched++; $display("FAIL mismatch_result: got %b required %b", sb_got, sb_exp); end
    end
    compared++; if (got_q.size() != 0) begin mismatched++; $display("FAIL mismatch_extra: %0d extra pulses, required 0", got_q.size()); end
    got_q.delete();
  endtask

  task automatic test_held_keys;
    mem[0] = 4'b0001;
    exp_q.push_back({1'b0, 1'b1, 3'd0});
    keys = 4'b0011;
    start_check(3'd0);
    tick(5);
    compared++; if (busy !== 1'b1 || got_q.size() != 0) begin mismatched++; $display("FAIL held_ignored: busy=%b pulses=%0d required 1 0", busy, got_q.size()); end
    keys = 4'b0000;
    tick(3);
    keys = 4'b0011;
    tick(1);
    compared++; if (fail !== 1'b1) begin mismatched++; $display("FAIL held_multi_fail: got %b required 1", fail); end
    keys = 4'b0000;
    tick(1);
    for (int w = 0; w < 40 && got_q.size() < exp_q.size(); w++) tick(1);
    while (exp_q.size() != 0) begin
      sb_exp = exp_q.pop_front();
      if (got_q.size() != 0) sb_got = got_q.pop_front(); else sb_got = 5'bxxxxx;
      compared++; if (sb_got !== sb_exp) begin mismatched++; $display("FAIL held_result: got %b required %b", sb_got, sb_exp); end
    end
    compared++; if (got_q.size() != 0) begin mismatched++; $display("FAIL held_extra: %0d extra pulses, required 0", got_q.size()); end
    got_q.delete();
  endtask

  task automatic test_level7;
    for (int i = 0; i < 8; i++) mem[i] = 4'b0001 << $urandom_range(0, 3);
    exp_q.push_back({1'b1, 1'b0, 3'd7});
    addr_log.delete();
    start_check(3'd7);
    level = 3'd0;
    tick(3);
    for (int i = 0; i < 8; i++) press(mem[i]);
    for (int w = 0; w < 40 && got_q.size() < exp_q.size(); w++) tick(1);
    while (exp_q.size() != 0) begin
      sb_exp = exp_q.pop_front();
      if (got_q.size() != 0) sb_got = got_q.pop_front(); else sb_got = 5'bxxxxx;
      compared++; if (sb_got !== sb_exp) begin mismatched++; $display("FAIL level7_result: got %b required %b", sb_got, sb_exp); end
    end
    compared++; if (got_q.size() != 0) begin mismatched++; $display("FAIL level7_extra: %0d extra pulses, required 0", got_q.size()); end
    got_q.delete();
    compared++; if (addr_log.size() != 8) begin mismatched++; $display("FAIL level7_addr_count: got %0d addresses required 8", addr_log.size()); end
    for (int i = 0; i < 8 && i < addr_log.size(); i++) begin
      compared++; if (addr_log[i] !== 5'(i)) begin mismatched++; $display("FAIL level7_addr_order: step %0d got %0d required %0d", i, addr_log[i], i); end
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 6; i++) mem[i] = 4'b0001 << $urandom_range(0, 3);
    start_check(3'd5);
    tick(3);
    press(mem[0]);
    press(mem[1]);
    press(mem[2]);
    keys = mem[3];
    tick(1);
    compared++; if (moveNum !== 3'd3 || busy !== 1'b1) begin mismatched++; $display("FAIL midreset_setup: moveNum=%0d busy=%b required 3 1", moveNum, busy); end
    reset = 1'b0;
    tick(1);
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL midreset_busy: got %b required 0", busy); end
    compared++; if (moveNum !== 3'd0) begin mismatched++; $display("FAIL midreset_movenum: got %0d required 0", moveNum); end
    compared++; if (pass !== 1'b0 || fail !== 1'b0) begin mismatched++; $display("FAIL midreset_pulse: pass=%b fail=%b required 0 0", pass, fail); end
    reset = 1'b1;
    keys = 4'b0000;
    tick(10);
    compared++; if (got_q.size() != 0) begin mismatched++; $display("FAIL midreset_extra: %0d pulses after abort, required 0", got_q.size()); end
    got_q.delete();
  endtask

  task automatic test_timeout;
    mem[0] = 4'b0100;
    start_check(3'd0);
    tick(3);
`ifdef CHECK_TIMEOUT_EN
    exp_q.push_back({1'b0, 1'b1, 3'd0});
    tick(15);
    compared++; if (fail !== 1'b0 || busy !== 1'b1) begin mismatched++; $display("FAIL timeout_early: fail=%b busy=%b required 0 1", fail, busy); end
    tick(1);
    compared++; if (fail !== 1'b1) begin mismatched++; $display("FAIL timeout_fail: got %b required 1 at 16 cycles", fail); end
    tick(1);
    for (int w = 0; w < 40 && got_q.size() < exp_q.size(); w++) tick(1);
    while (exp_q.size() != 0) begin
      sb_exp = exp_q.pop_front();
      if (got_q.size() != 0) sb_got = got_q.pop_front(); else sb_got = 5'bxxxxx;
      compared++; if (sb_got !== sb_exp) begin mismatched++; $display("FAIL timeout_result: got %b required %b", sb_got, sb_exp); end
    end
`else
    tick(1000);
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL notimeout_busy: got %b required 1", busy); end
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(1);
`endif
    compared++; if (got_q.size() != 0) begin mismatched++; $display("FAIL timeout_extra: %0d extra pulses, required 0", got_q.size()); end
    got_q.delete();
  endtask

  task automatic test_back_to_back;
    mem[0] = 4'b1000; mem[1] = 4'b0001;
    exp_q.push_back({1'b1, 1'b0, 3'd1});
    exp_q.push_back({1'b1, 1'b0, 3'd1});
    start_check(3'd1);
    tick(3);
    press(4'b1000);
    start = 1'b1;
    level = 3'd0;
    tick(1);
    start = 1'b0;
    press(4'b0001);
    start_check(3'd1);
    tick(3);
    press(4'b1000);
    press(4'b0001);
    for (int w = 0; w < 40 && got_q.size() < exp_q.size(); w++) tick(1);
    while (exp_q.size() != 0) begin
      sb_exp = exp_q.pop_front();
      if (got_q.size() != 0) sb_got = got_q.pop_front(); else sb_got = 5'bxxxxx;
      compared++; if (sb_got !== sb_exp) begin mismatched++; $display("FAIL b2b_result: got %b required %b", sb_got, sb_exp); end
    end
    tick(3);
    compared++; if (got_q.size() != 0) begin mismatched++; $display("FAIL b2b_extra: %0d extra pulses, required 0", got_q.size()); end
    got_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 4'b0000;
    test_reset;
    test_min_latency;
    test_basic_pass;
    test_mismatch;
    test_held_keys;
    test_level7;
    test_reset_mid;
    test_timeout;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
